// File: rtl/ws2812_bit_decoder_if.sv
// Signal bundle between the input synchroniser, the WS2812 bit decoder and the bit-assembly stage.
// WS2812_DECODER_ERR_STATS_EN adds the o_err_count statistics output.
`timescale 1ns/1ps

interface ws2812_bit_decoder_if;
  logic       i_din;
  logic       o_bit;
  logic       o_bit_valid;
  logic       o_latch;
  logic       o_err;
  logic [1:0] o_err_code;
  logic       o_sync;
`ifdef WS2812_DECODER_ERR_STATS_EN
  logic [15:0] o_err_count;

  modport slave  (input i_din, output o_bit, output o_bit_valid, output o_latch,
                  output o_err, output o_err_code, output o_sync, output o_err_count);
  modport master (output i_din, input o_bit, input o_bit_valid, input o_latch,
                  input o_err, input o_err_code, input o_sync, input o_err_count);
`else
  modport slave  (input i_din, output o_bit, output o_bit_valid, output o_latch,
                  output o_err, output o_err_code, output o_sync);
  modport master (output i_din, input o_bit, input o_bit_valid, input o_latch,
                  input o_err, input o_err_code, input o_sync);
`endif
endinterface

// File: rtl/ws2812_bit_decoder.sv
// WS2812 bit decoder: times high/low phases, emits bits, latch strobes and classified errors.
// Optional feature macro: WS2812_DECODER_ERR_STATS_EN (16-bit saturating error counter).
`timescale 1ns/1ps

// state  | meaning
// S_SYNC | waiting for a reset-code length low before trusting the line
// S_IDLE | frame boundary seen, waiting for the first rising edge
// S_HIGH | timing a high phase
// S_LOW  | timing the low phase that follows a classified high phase
module ws2812_bit_decoder #(
  parameter int CNT_W    = 12,
  parameter int T0H_MIN  = 12,
  parameter int T0H_MAX  = 28,
  parameter int T1H_MIN  = 32,
  parameter int T1H_MAX  = 48,
  parameter int TL_MIN   = 12,
  parameter int TL_MAX   = 50,
  parameter int TRES_MIN = 2500
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  ws2812_bit_decoder_if.slave  bus
);

  if (!(T0H_MAX < T1H_MIN)) begin : g_chk_th
    $error("ws2812_bit_decoder: T0H_MAX must be below T1H_MIN");
  end
  if (!(TL_MAX < TRES_MIN)) begin : g_chk_tl
    $error("ws2812_bit_decoder: TL_MAX must be below TRES_MIN");
  end
  if (TRES_MIN > ((1 << CNT_W) - 1)) begin : g_chk_tres
    $error("ws2812_bit_decoder: TRES_MIN does not fit in the phase counter");
  end

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] T0H_MIN_C  = CNT_W'(T0H_MIN);
  localparam logic [CNT_W-1:0] T0H_MAX_C  = CNT_W'(T0H_MAX);
  localparam logic [CNT_W-1:0] T1H_MIN_C  = CNT_W'(T1H_MIN);
  localparam logic [CNT_W-1:0] T1H_MAX_C  = CNT_W'(T1H_MAX);
  localparam logic [CNT_W-1:0] TL_MIN_C   = CNT_W'(TL_MIN);
  localparam logic [CNT_W-1:0] TL_MAX_C   = CNT_W'(TL_MAX);
  localparam logic [CNT_W-1:0] TRES_MIN_C = CNT_W'(TRES_MIN);

  typedef enum logic [1:0] {S_SYNC, S_IDLE, S_HIGH, S_LOW} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             din_q;
  logic             pend_q;
  logic             bit_q;
  logic             bit_valid_q;
  logic             latch_q;
  logic             err_q;
  logic [1:0]       err_code_q;
  logic             sync_q;

  logic din_edge, rise, fall;
  logic high_is_1, high_is_0, low_ok, tres_hit, err_det;

  assign din_edge = bus.i_din ^ din_q;
  assign rise     = din_edge & bus.i_din;
  assign fall     = din_edge & ~bus.i_din;

  // cnt_q holds the length of the phase that the current edge terminates.
  assign high_is_1 = (cnt_q >= T1H_MIN_C) && (cnt_q <= T1H_MAX_C);
  assign high_is_0 = (cnt_q >= T0H_MIN_C) && (cnt_q <= T0H_MAX_C);
  assign low_ok    = (cnt_q >= TL_MIN_C) && (cnt_q <= TL_MAX_C);
  assign tres_hit  = ~din_edge && ~bus.i_din && (cnt_q >= TRES_MIN_C);
  assign err_det   = ((state_q == S_HIGH) && fall && !high_is_1 && !high_is_0) ||
                     ((state_q == S_LOW) && rise && !low_ok);

  always_comb begin
    cnt_d = cnt_q;
    if (din_edge) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_SYNC;
      cnt_q       <= '0;
      din_q       <= 1'b0;
      pend_q      <= 1'b0;
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
      latch_q     <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
      sync_q      <= 1'b0;
    end else begin
      din_q       <= bus.i_din;
      cnt_q       <= cnt_d;
      bit_valid_q <= 1'b0;
      latch_q     <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
      case (state_q)
        S_SYNC: begin
          if (tres_hit) begin
            state_q <= S_IDLE;
            sync_q  <= 1'b1;
          end
        end
        S_IDLE: begin
          if (rise) begin
            state_q <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (fall) begin
            if (high_is_1) begin
              pend_q  <= 1'b1;
              state_q <= S_LOW;
            end else if (high_is_0) begin
              pend_q  <= 1'b0;
              state_q <= S_LOW;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= 2'b01;
              state_q    <= S_SYNC;
              sync_q     <= 1'b0;
            end
          end
        end
        S_LOW: begin
          if (rise) begin
            if (low_ok) begin
              bit_valid_q <= 1'b1;
              bit_q       <= pend_q;
              state_q     <= S_HIGH;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= 2'b10;
              pend_q     <= 1'b0;
              state_q    <= S_SYNC;
              sync_q     <= 1'b0;
            end
          end else if (tres_hit) begin
            // A reset code also terminates the last bit of the frame.
            bit_valid_q <= 1'b1;
            bit_q       <= pend_q;
            latch_q     <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_SYNC;
          sync_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef WS2812_DECODER_ERR_STATS_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      err_cnt_q <= '0;
    end else if (err_det && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign bus.o_err_count = err_cnt_q;
`else
  logic unused_err_det;
  assign unused_err_det = err_det;
`endif

  assign bus.o_bit       = bit_q;
  assign bus.o_bit_valid = bit_valid_q;
  assign bus.o_latch     = latch_q;
  assign bus.o_err       = err_q;
  assign bus.o_err_code  = err_code_q;
  assign bus.o_sync      = sync_q;

endmodule

// File: doc/ws2812_bit_decoder.md
Name: ws2812_bit_decoder

Overview:
Parametrised WS2812 bit decoder for the LED-input receive path.
- Measures both the high and the low phase of each bit and classifies the high phase against run-time-fixed T0H/T1H windows.
- Emits a decoded bit only after the following low phase is validated.
- Detects the reset/latch code, reports classified errors and re-synchronises to frame boundaries after reset or error.
- Sits between the input synchroniser and the bit-assembly stage.

Parameters:
- CNT_W, 12, phase counter width; counter saturates at 2^CNT_W-1.
- T0H_MIN, 12, min high cycles for a 0 bit.
- T0H_MAX, 28, max high cycles for a 0 bit.
- T1H_MIN, 32, min high cycles for a 1 bit.
- T1H_MAX, 48, max high cycles for a 1 bit.
- TL_MIN, 12, min low cycles between bits.
- TL_MAX, 50, max low cycles between bits.
- TRES_MIN, 2500, low cycles that constitute the reset/latch code.
- Elaboration-time checks: T0H_MAX < T1H_MIN, TL_MAX < TRES_MIN, TRES_MIN <= 2^CNT_W-1.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  reset; asynchronous, active-low.
- i_din  in  1  WS2812 data line, already synchronised to i_clk.
- o_bit  out  1  decoded bit; meaningful only when o_bit_valid=1.
- o_bit_valid  out  1  one-cycle strobe: o_bit accepted.
- o_latch  out  1  one-cycle strobe: reset code detected (frame end).
- o_err  out  1  one-cycle strobe: timing violation.
- o_err_code  out  2  01 = high out of window, 10 = low out of window, 00 otherwise.
- o_sync  out  1  1 when aligned, i.e. state is not SYNC.

Behaviour:
Reset values:
- All outputs 0, o_err_code=00, state=SYNC, counter=0, internal r_din=0, pending bit cleared.
- Reset asserted mid-operation discards any pending bit; no strobe is produced.

Edge detection and counter:
- Edge = i_din != r_din, where r_din is i_din delayed one clock.
- On an edge the counter loads 1; otherwise it increments, saturating at 2^CNT_W-1.
- The measured phase length equals the counter value on the cycle the terminating edge is detected.

SYNC:
- Ignore data.
- When i_din=0 and the counter reaches TRES_MIN, go to IDLE. No o_latch strobe in this case.

IDLE:
- A rising edge moves to HIGH.

HIGH, on a falling edge, high count h:
- If T1H_MIN <= h <= T1H_MAX: pending = 1, go to LOW.
- Else if T0H_MIN <= h <= T0H_MAX: pending = 0, go to LOW.
- Otherwise: o_err=1, code=01, go to SYNC.

LOW, low count l:
- On a rising edge with TL_MIN <= l <= TL_MAX: emit pending bit, go to HIGH.
- On a rising edge with l outside that window: o_err=1, code=10, pending discarded, go to SYNC.
- If no edge occurs and the counter reaches TRES_MIN: emit pending bit AND pulse o_latch in the same cycle, go to IDLE.

Strobe timing:
- All strobes are registered and appear the cycle after the detecting cycle.
- Each strobe is exactly 1 cycle wide; there are no back-to-back duplicates.

Limits and sustained levels:
- High held beyond 2^CNT_W-1 cycles: counter saturates, no strobe until the falling edge, which then reports code 01.
- Line held low indefinitely: o_latch pulses once only; the counter saturates silently.

Optional Feature:
Macro WS2812_DECODER_ERR_STATS_EN.
- Defined:
  - Adds output o_err_count (16 bits).
  - Increments on every o_err strobe and saturates at 0xFFFF.
  - Cleared only by i_reset_n.
- Undefined:
  - Port and logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset release, then i_din low for 2500 cycles -> o_sync=1 and no o_latch. Then high 40 / low 20 / high 20 -> o_bit_valid with o_bit=1, one cycle after the second rising edge.
- Synced, then high 20 followed by low 2500 -> o_bit_valid with o_bit=0 and o_latch in the same cycle, 2501 cycles after the falling edge. No further strobes for another 3000 low cycles.
- Synced, then high 30 (gap between windows) -> o_err=1, code=01, o_sync=0. A subsequent valid bit is ignored until 2500 low cycles have elapsed.
- Synced, then high 40 / low 8 / rising edge -> o_err, code=10, no o_bit_valid. Repeat with low 100 -> code=10.
- i_reset_n asserted 5 cycles into a high phase -> outputs 0 immediately, state=SYNC, no strobes after release.
- With WS2812_DECODER_ERR_STATS_EN defined: three errors -> o_err_count=3. Force 70000 errors -> o_err_count=0xFFFF.
